lh_host_verifier: RTL and testbench

- Host-side counterpart of the light-hash core: buffers an upstream message and streams it into the core one character per cycle on ptxt_char/ptxt_valid.
- Waits for digest_ready, compares the returned 64-bit digest against an expected digest, and reports match or error on a one-cycle result strobe.
- Sits between the message source (bus/UART bridge) and the light_hash core.

---
 rtl/lh_pkg.sv | 42 ++++
 rtl/lh_host_verifier_fifo.sv | 64 ++++++
 rtl/lh_host_verifier.sv | 205 ++++++++++++++++++++
 tb/tb_lh_host_verifier.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lh_pkg.sv
// ---------------------------------------------------------------------------
// lh_pkg - shared definitions for the light-hash core and its host verifier.
//   LH_DIGEST_W      : digest width of the current core (64)
//   LH_ASCII_*       : inclusive bounds of the accepted character classes
//   lh_host_state_t  : host verifier FSM states
//   lh_err_t         : res_err encoding
//   is_alnum()       : true for 0-9, A-Z, a-z
// ---------------------------------------------------------------------------
package lh_pkg;

    localparam int LH_DIGEST_W = 64;

    localparam logic [7:0] LH_ASCII_0  = 8'h30;
    localparam logic [7:0] LH_ASCII_9  = 8'h39;
    localparam logic [7:0] LH_ASCII_UA = 8'h41;
    localparam logic [7:0] LH_ASCII_UZ = 8'h5A;
    localparam logic [7:0] LH_ASCII_LA = 8'h61;
    localparam logic [7:0] LH_ASCII_LZ = 8'h7A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DROP,
        ST_SEND,
        ST_WAIT,
        ST_REPORT
    } lh_host_state_t;

    typedef enum logic [1:0] {
        LH_OK          = 2'd0,
        LH_ERR_CHAR    = 2'd1,
        LH_ERR_TIMEOUT = 2'd2,
        LH_ERR_LEN     = 2'd3
    } lh_err_t;

    function automatic logic is_alnum(input logic [7:0] c);
        return ((c >= LH_ASCII_0)  && (c <= LH_ASCII_9))  ||
               ((c >= LH_ASCII_UA) && (c <= LH_ASCII_UZ)) ||
               ((c >= LH_ASCII_LA) && (c <= LH_ASCII_LZ));
    endfunction

endpackage

// File: rtl/lh_host_verifier_fifo.sv
// ---------------------------------------------------------------------------
// lh_char_fifo - small synchronous circular FIFO for message characters.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop all contents (wins over push/pop)
//   push, din  : write one entry when not full
//   pop, dout  : dout always shows the head entry; pop advances it
//   full, empty, count : occupancy (count is clog2(DEPTH)+1 bits)
// The head is read combinationally so the host can forward a character on
// the cycle it pops it.
// ---------------------------------------------------------------------------
module lh_char_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (push && !full) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            count_reg  <= count_reg + 1'b1;
        end else if (pop && !empty) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg  <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/lh_host_verifier.sv
// ---------------------------------------------------------------------------
// lh_host_verifier - buffers an upstream message, streams it to the
// light-hash core one character per cycle, then compares the returned digest
// with the expected digest and reports on a one-cycle res_valid strobe.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_char/in_valid/in_last/in_ready : upstream message beats
//   exp_digest                     : expected digest, taken with in_last
//   ptxt_char/ptxt_valid/ptxt_last : character stream to the core
//   digest_char/digest_ready       : digest returned by the core
//   busy                           : FSM not idle
//   res_valid/res_match/res_err/res_digest : result report
// Optional build macro LH_VERIFY_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on
// the digest wait; without it WAIT waits indefinitely.
// ---------------------------------------------------------------------------
module lh_host_verifier
    import lh_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DIGEST_W       = LH_DIGEST_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_char,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic [DIGEST_W-1:0] exp_digest,
    output logic [7:0]          ptxt_char,
    output logic                ptxt_valid,
    output logic                ptxt_last,
    input  logic [DIGEST_W-1:0] digest_char,
    input  logic                digest_ready,
    output logic                busy,
    output logic                res_valid,
    output logic                res_match,
    output logic [1:0]          res_err,
    output logic [DIGEST_W-1:0] res_digest
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || DIGEST_W != LH_DIGEST_W) begin : g_param_check
        $error("lh_host_verifier: unsupported parameter set");
    end

    lh_host_state_t      state_reg;
    logic [DIGEST_W-1:0] exp_reg;
    logic                running_reg;   // holds in_ready low until the first clock after reset

    logic          accept;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          char_ok;
    logic          last_entry;
    logic          collecting;

`ifdef LH_VERIFY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_reg;
`endif

    assign collecting = (state_reg == ST_IDLE) || (state_reg == ST_FILL);
    assign in_ready   = running_reg &&
                        ((collecting && !fifo_full) || (state_reg == ST_DROP));
    assign accept     = in_valid && in_ready;
    assign busy       = (state_reg != ST_IDLE);

    always_comb begin
        char_ok    = is_alnum(fifo_dout);
        last_entry = (fifo_count == CW'(1));
        fifo_push  = accept && collecting;
        fifo_pop   = (state_reg == ST_SEND) && !fifo_empty && char_ok;
        // Flush when abandoning an overlong message or an invalid one.
        fifo_flush = ((state_reg == ST_FILL) && fifo_full) ||
                     ((state_reg == ST_SEND) && !fifo_empty && !char_ok);
    end

    lh_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (in_char),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            exp_reg     <= '0;
            running_reg <= 1'b0;
            ptxt_char   <= '0;
            ptxt_valid  <= 1'b0;
            ptxt_last   <= 1'b0;
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_err     <= LH_OK;
            res_digest  <= '0;
`ifdef LH_VERIFY_TIMEOUT_EN
            tmo_reg     <= '0;
`endif
        end else begin
            running_reg <= 1'b1;
            ptxt_valid  <= 1'b0;
            ptxt_last   <= 1'b0;
            res_valid   <= 1'b0;

            // res_valid is raised on the transition into REPORT so that it
            // coincides with the REPORT state for exactly one cycle.
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            exp_reg   <= exp_digest;
                            state_reg <= ST_SEND;
                        end else begin
                            state_reg <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        if (in_last) begin
                            exp_reg   <= exp_digest;
                            state_reg <= ST_SEND;
                        end
                    end else if (fifo_full) begin
                        res_err    <= LH_ERR_LEN;
                        res_match  <= 1'b0;
                        res_digest <= '0;
                        state_reg  <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (accept && in_last) begin
                        res_valid <= 1'b1;
                        state_reg <= ST_REPORT;
                    end
                end
                ST_SEND: begin
                    if (fifo_empty) begin
                        state_reg <= ST_IDLE;
                    end else if (char_ok) begin
                        ptxt_valid <= 1'b1;
                        ptxt_char  <= fifo_dout;
                        ptxt_last  <= last_entry;
                        if (last_entry) begin
                            state_reg <= ST_WAIT;
`ifdef LH_VERIFY_TIMEOUT_EN
                            tmo_reg   <= '0;
`endif
                        end
                    end else begin
                        res_err    <= LH_ERR_CHAR;
                        res_match  <= 1'b0;
                        res_digest <= '0;
                        res_valid  <= 1'b1;
                        state_reg  <= ST_REPORT;
                    end
                end
                ST_WAIT: begin
                    if (digest_ready) begin
                        res_digest <= digest_char;
                        res_match  <= (digest_char == exp_reg);
                        res_err    <= LH_OK;
                        res_valid  <= 1'b1;
                        state_reg  <= ST_REPORT;
                    end
`ifdef LH_VERIFY_TIMEOUT_EN
                    else if (tmo_reg == TW'(TIMEOUT_CYCLES)) begin
                        res_digest <= '0;
                        res_match  <= 1'b0;
                        res_err    <= LH_ERR_TIMEOUT;
                        res_valid  <= 1'b1;
                        state_reg  <= ST_REPORT;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
`endif
                end
                ST_REPORT: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lh_host_verifier.sv
// ---------------------------------------------------------------------------
// tb_lh_host_verifier - directed self-checking bench for lh_host_verifier.
// A stub core answers with a fixed digest 3 cycles after it sees ptxt_last.
// ---------------------------------------------------------------------------
module tb_lh_host_verifier;

    localparam logic [63:0] DIG = 64'h0123456789ABCDEF;
`ifdef LH_VERIFY_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_char = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [63:0] exp_digest = '0;
    logic [7:0]  ptxt_char;
    logic        ptxt_valid;
    logic        ptxt_last;
    logic [63:0] digest_char;
    logic        digest_ready = 1'b0;
    logic        busy;
    logic        res_valid;
    logic        res_match;
    logic [1:0]  res_err;
    logic [63:0] res_digest;

    int tests = 0;
    int fails = 0;
    int res_cnt = 0;
    int cyc = 0;
    int rcyc = 0;
    bit stub_en = 1'b1;
    logic [3:0] stub_cnt = '0;

    logic [7:0] pq[$];
    logic       lq[$];
    int         cq[$];

    assign digest_char = DIG;

    always #5 clk = ~clk;

    lh_host_verifier #(
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (TMO),
        .DIGEST_W       (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_char      (in_char),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .exp_digest   (exp_digest),
        .ptxt_char    (ptxt_char),
        .ptxt_valid   (ptxt_valid),
        .ptxt_last    (ptxt_last),
        .digest_char  (digest_char),
        .digest_ready (digest_ready),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_match    (res_match),
        .res_err      (res_err),
        .res_digest   (res_digest)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Stub hash core.
    always @(posedge clk) begin
        digest_ready <= 1'b0;
        if (ptxt_valid && ptxt_last && stub_en) begin
            stub_cnt <= 4'd3;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1'b1;
            if (stub_cnt == 4'd1) digest_ready <= 1'b1;
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (ptxt_valid) begin
            pq.push_back(ptxt_char);
            lq.push_back(ptxt_last);
            cq.push_back(cyc);
        end
        if (res_valid) begin
            res_cnt++;
            rcyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] c, input logic l, input logic [63:0] e);
        int n = 0;
        in_char = c; in_last = l; exp_digest = e; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic send_str(input string s, input logic [63:0] e);
        pq.delete(); lq.delete(); cq.delete();
        for (int i = 0; i < s.len(); i++) beat(s[i], (i == s.len() - 1), e);
        in_valid = 1'b0; in_last = 1'b0;
        $display("[TB] sent \"%s\" exp=%h", s, e);
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < 300) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd1);
        $display("[TB] %s result: match=%0d err=%0d digest=%h chars=%0d",
                 tag, res_match, res_err, res_digest, pq.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_ptxt", {54'd0, ptxt_valid, ptxt_last, ptxt_char}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_res", {60'd0, res_valid, res_match, res_err}, 64'd0);
        check("rst_res_digest", res_digest, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // "Ab9", matching digest
        send_str("Ab9", DIG);
        wait_res("ab9_match");
        check("ab9_count", pq.size(), 3);
        check("ab9_c0", pq[0], 8'h41);
        check("ab9_c1", pq[1], 8'h62);
        check("ab9_c2", pq[2], 8'h39);
        check("ab9_last", {lq[0], lq[1], lq[2]}, 3'b001);
        check("ab9_consec", {cq[1] - cq[0], cq[2] - cq[1]}, {32'd1, 32'd1});
        check("ab9_match", {res_match, res_err}, 3'b100);
        check("ab9_digest", res_digest, DIG);
        repeat (3) @(negedge clk);
        #1;
        check("ab9_one_pulse", res_cnt, 1);
        check("ab9_idle", {63'd0, busy}, 64'd0);

        // Same message, expected digest 0
        send_str("Ab9", 64'h0);
        wait_res("ab9_nomatch");
        check("nm_match", {res_match, res_err}, 3'b000);
        check("nm_digest", res_digest, DIG);
        check("nm_count", pq.size(), 3);

        // "A#b" invalid character
        repeat (2) @(negedge clk);
        #1;
        send_str("A#b", DIG);
        wait_res("invalid");
        check("inv_count", pq.size(), 1);
        check("inv_c0", pq[0], 8'h41);
        check("inv_nolast", {63'd0, lq[0]}, 64'd0);
        check("inv_err", {res_match, res_err}, 3'b001);
        check("inv_digest", res_digest, 64'd0);

        // "Z" afterwards
        repeat (2) @(negedge clk);
        #1;
        send_str("Z", DIG);
        wait_res("z");
        check("z_char", {lq[0], pq[0]}, {1'b1, 8'h5A});
        check("z_count", pq.size(), 1);
        check("z_match", {res_match, res_err}, 3'b100);
        repeat (3) @(negedge clk);
        #1;
        check("z_res_cnt", res_cnt, 4);

        // 20 characters overflow a 16-deep buffer
        send_str("ABCDEFGHIJKLMNOPQRST", DIG);
        wait_res("overflow");
        check("ovf_err", {res_match, res_err}, 3'b011);
        check("ovf_no_ptxt", pq.size(), 0);
        check("ovf_digest", res_digest, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("ovf_busy", {63'd0, busy}, 64'd0);
        check("ovf_res_cnt", res_cnt, 5);

        // Reset in the middle of SEND of "abcd"
        send_str("abcd", DIG);
        begin
            int n = 0;
            while (pq.size() < 2 && n < 50) begin
                @(negedge clk); #1; n++;
            end
        end
        check("abort_pre_chars", pq.size(), 2);
        check("abort_pre_valid", {63'd0, ptxt_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_async_valid", {63'd0, ptxt_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_res", res_cnt, 5);
        check("abort_no_more_chars", pq.size(), 2);
        $display("[TB] reset during SEND: chars=%0d res_cnt=%0d", pq.size(), res_cnt);

        // Post-reset "x"
        send_str("x", DIG);
        wait_res("x");
        check("x_char", {lq[0], pq[0]}, {1'b1, 8'h78});
        check("x_match", {res_match, res_err, res_digest}, {1'b1, 2'b00, DIG});
        repeat (3) @(negedge clk);
        #1;
        check("x_res_cnt", res_cnt, 6);

`ifdef LH_VERIFY_TIMEOUT_EN
        // Stub silent: timeout
        stub_en = 1'b0;
        send_str("Ab9", DIG);
        wait_res("timeout");
        check("tmo_err", {res_match, res_err}, 3'b010);
        check("tmo_digest", res_digest, 64'd0);
        check("tmo_latency", rcyc - cq[2], 9);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
